// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared definitions for the programmable synchronous FIFO:
//   DEF_DEPTH / DEF_DATA_WIDTH - default geometry
//   fifo_mode_e                - read mode (STD registered read, FWFT fall-through)
//   ptr_w()                    - pointer width for a given depth
package sync_fifo_pkg;

  localparam int DEF_DEPTH      = 16;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } fifo_mode_e;

  // Width of a pointer that addresses 'depth' entries. Clamped to 1 so a
  // degenerate depth still elaborates far enough to hit the parameter check.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if
// Producer/consumer side of the FIFO bundled as one interface.
//   slave  : FIFO view   (inputs clr, w_en, data_in, r_en; outputs data_out,
//            full, empty, almost_full, almost_empty, count, overflow, underflow)
//   master : user view   (directions mirrored)
interface sync_fifo_prog_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);
  localparam int CW = ptr_w(DEPTH) + 1;

  logic                  clr;
  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  clr, w_en, data_in, r_en,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport master (
    output clr, w_en, data_in, r_en,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
// DEPTH x DATA_WIDTH storage, one synchronous write port, one asynchronous
// read port, no reset (contents are don't-care until written).
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational from raddr_i)
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [ptr_w(DEPTH)-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [ptr_w(DEPTH)-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, overflow/underflow pulses, synchronous flush and a
// selectable read mode (registered standard read or first-word-fall-through).
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of sync_fifo_prog_if (clr, w_en, data_in, r_en in;
//           data_out, full, empty, almost_full, almost_empty, count,
//           overflow, underflow out)
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_prog_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam fifo_mode_e MODE = fifo_mode_e'(FWFT != 0);

  // Elaboration-time parameter checks
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_prog: DEPTH=%0d must be a power of 2 and >= 4", DEPTH);
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_prog: AF_THRESH=%0d outside 1..DEPTH", AF_THRESH);
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_prog: AE_THRESH=%0d outside 0..DEPTH-1", AE_THRESH);
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
    $fatal(1, "sync_fifo_prog: FWFT=%0d must be 0 or 1", FWFT);
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full_w, empty_w;
  logic                  wr_accept, rd_accept;

  // Flags come straight from the count register, so they never glitch.
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // A flush swallows both requests, so they are neither accepted nor flagged.
  assign wr_accept = bus.w_en && !full_w  && !bus.clr;
  assign rd_accept = bus.r_en && !empty_w && !bus.clr;

  sync_fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = bus.w_en && full_w  && !bus.clr;
    underflow_d = bus.r_en && empty_w && !bus.clr;

    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are log2(DEPTH) bits wide, so they wrap on their own.
      if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (MODE == STD) begin : g_std
    // Registered read: the popped word appears one cycle after r_en and
    // holds until the next accepted read or a flush.
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
      data_d = data_q;
      if (bus.clr)        data_d = '0;
      else if (rd_accept) data_d = rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
    end

    assign bus.data_out = data_q;
  end else begin : g_fwft
    // Head word shown directly from storage; forced to zero while empty so
    // stale contents never leak out.
    assign bus.data_out = empty_w ? '0 : rd_data;
  end

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
